// File: rtl/bcd_down1000.sv
// Three-digit BCD down-counter (000..999) with load, start/stop control,
// a one-cycle expiry pulse and optional automatic reload.
module bcd_down1000 #(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [3:0] LD001,
   input  logic [3:0] LD010,
   input  logic [3:0] LD100,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] CNT001,
   output logic [3:0] CNT010,
   output logic [3:0] CNT100,
   output logic       running,
   output logic       done,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSE   = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [11:0] r_cnt;
   logic [11:0] w_cnt_nxt;
   logic [11:0] r_reload;
   logic [11:0] w_reload_nxt;
   logic        r_done;
   logic        w_done_nxt;
   logic        r_running;
   logic [11:0] w_ld_clamped;
   logic [11:0] w_dec;
   logic        w_is_one;
   logic        w_is_zero;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign w_ld_clamped = {clamp9(LD100), clamp9(LD010), clamp9(LD001)};
   assign w_is_one     = (r_cnt == 12'h001);
   assign w_is_zero    = (r_cnt == 12'h000);

   // BCD decrement; hundreds is nonzero whenever both lower digits borrow here.
   always_comb begin
      w_dec[3:0]  = (r_cnt[3:0] == 4'd0) ? 4'd9 : r_cnt[3:0] - 4'd1;
      w_dec[7:4]  = r_cnt[7:4];
      w_dec[11:8] = r_cnt[11:8];
      if (r_cnt[3:0] == 4'd0) begin
         w_dec[7:4] = (r_cnt[7:4] == 4'd0) ? 4'd9 : r_cnt[7:4] - 4'd1;
         if (r_cnt[7:4] == 4'd0) begin
            w_dec[11:8] = r_cnt[11:8] - 4'd1;
         end
      end
   end

   // Priority load > stop > start > tick; start only consumes the cycle
   // in states where it actually acts.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_reload_nxt = r_reload;
      w_done_nxt   = 1'b0;
      if (load) begin
         w_cnt_nxt    = w_ld_clamped;
         w_reload_nxt = w_ld_clamped;
         w_state_nxt  = S_IDLE;
      end else if (stop) begin
         if (r_state == S_RUN) begin
            w_state_nxt = S_PAUSE;
         end
      end else if (start && (r_state == S_IDLE || r_state == S_PAUSE)) begin
         w_state_nxt = w_is_zero ? S_EXPIRED : S_RUN;
      end else if (tick && r_state == S_RUN) begin
         if (w_is_zero) begin
            w_state_nxt = S_EXPIRED;
         end else if (w_is_one) begin
            w_done_nxt = 1'b1;
            if (AUTO_RELOAD && r_reload != 12'h000) begin
               w_cnt_nxt = r_reload;
            end else begin
               w_cnt_nxt   = 12'h000;
               w_state_nxt = S_EXPIRED;
            end
         end else begin
            w_cnt_nxt = w_dec;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 12'h000;
         r_reload  <= 12'h000;
         r_done    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_reload  <= w_reload_nxt;
         r_done    <= w_done_nxt;
         r_running <= (w_state_nxt == S_RUN);
      end
   end

   assign CNT100  = r_cnt[11:8];
   assign CNT010  = r_cnt[7:4];
   assign CNT001  = r_cnt[3:0];
   assign running = r_running;
   assign done    = r_done;
   assign o_state = r_state;

endmodule

// File: doc/bcd_down1000.md
BCD_DOWN1000 -- requirements
Module: bcd_down1000

Interface
REQ-001 Parameter AUTO_RELOAD, default 0; when 1, the counter reloads the last loaded value on expiry and keeps running.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 tick  input  1  count-enable strobe, one decrement per cycle in which it is high; any rate, up to every cycle.
REQ-005 load  input  1  captures LD100/LD010/LD001 as the count and reload value.
REQ-006 LD001, LD010, LD100  input  4 each  BCD load digits (ones, tens, hundreds).
REQ-007 start  input  1  begins or resumes counting.
REQ-008 stop  input  1  pauses counting.
REQ-009 CNT001, CNT010, CNT100  output  4 each  registered BCD count digits.
REQ-010 running  output  1  high in state RUN.
REQ-011 done  output  1  registered, one-cycle pulse on expiry.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, PAUSE and EXPIRED.
REQ-013 Same-cycle control priority SHALL be: load > stop > start > tick.
REQ-014 Load: the count and reload register SHALL take the load digits on the next edge, and the state SHALL go to IDLE from any state.
REQ-015 Any load digit above 9 SHALL be clamped to 9 on capture; each other digit keeps its own value.
REQ-016 start in IDLE or PAUSE SHALL go to RUN, except when the count is 000, where the state goes to EXPIRED with no done pulse.
REQ-017 start in RUN or EXPIRED SHALL be ignored.
REQ-018 stop in RUN SHALL go to PAUSE with the count held; stop in other states SHALL be ignored.
REQ-019 In RUN with tick high, the count SHALL decrement by 1 in BCD:
  - The ones digit wraps 0->9 and borrows from the tens digit.
  - The tens digit wraps 0->9 and borrows from the hundreds digit.
REQ-020 A tick at count 001 SHALL take the count to 000 and assert done on the same edge.
REQ-021 With AUTO_RELOAD=0, the 001->000 decrement SHALL also move the state to EXPIRED.
REQ-022 With AUTO_RELOAD=1, a tick at 001 SHALL assert done and load the reload value on the same edge, and the state SHALL stay in RUN.
REQ-023 With AUTO_RELOAD=1 and a reload value of 000, the state SHALL go to EXPIRED.
REQ-024 In IDLE, PAUSE and EXPIRED, tick SHALL be ignored and the count SHALL hold.
REQ-025 The count SHALL never go below 000.
REQ-026 In EXPIRED the count SHALL hold at 000; only load or rst leaves EXPIRED.
REQ-027 done SHALL be high for exactly one cycle per expiry and low in every other cycle.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-029 Latency from a control input (load, start, stop) or tick to the output change SHALL be one clock edge.
REQ-030 The design SHALL be fully synchronous to clk apart from rst, with no derived or ripple clocks.

Reset
REQ-031 On rst high, the FSM SHALL go to IDLE immediately, with no clock required.
REQ-032 On rst high, CNT100/CNT010/CNT001 and the reload register SHALL be 0/0/0 immediately.
REQ-033 On rst high, running and done SHALL be 0 immediately.
REQ-034 rst asserted mid-count SHALL abort the count and suppress any pending done.
REQ-035 The first edge after rst deasserts SHALL honour the inputs normally.

Verification
REQ-036 Basic countdown: load 0/1/2 (12), start, tick every cycle.
  - Count steps 12, 11, 10, 09 ... 01, 00.
  - done is high for 1 cycle, on the same edge the count reaches 00.
  - The FSM ends in EXPIRED with running=0.
REQ-037 Borrow chain: load 1/0/0 (100), start, one tick.
  - Count reads 0/9/9 (099).
  - Hold tick low for 5 cycles; count stays 099.
REQ-038 Pause and resume, with load digits 9/9/9 (999) and AUTO_RELOAD=0:
  - Run 3 ticks; count reads 996.
  - Assert stop and tick together; count stays 996 and state is PAUSE.
  - Assert start, then 1 tick; count reads 995.
REQ-039 Auto-reload: AUTO_RELOAD=1, load 003, start, continuous ticks.
  - done pulses every 3 ticks.
  - The count sequence repeats 003, 002, 001, 003 ...
  - running stays 1 throughout.
REQ-040 Boundaries:
  - Load digits F/A/5 -> count reads 9/9/5.
  - Load 000, then start -> state EXPIRED, done stays 0.
  - load and start in the same cycle -> state IDLE.
REQ-041 Async reset: assert rst between clock edges mid-run at 457.
  - Outputs read 000 with running=0 before the next edge.
  - No done pulse follows.
